multicycle_ctrl: RTL and testbench



---
 rtl/multicycle_ctrl.sv | 175 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle LEGv8 control FSM: fetch/decode/execute/memory/writeback sequencing,
// memory-wait timeout, sticky halt and retired counter. Define CBNZ_EN to decode CBNZ.
module multicycle_ctrl #(
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      Op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             Reg2Loc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic             halt,
    output logic [1:0]       cause,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_o
);
    localparam int WAIT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX - 1);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECR   = 4'd6;
    localparam logic [3:0] S_RWB     = 4'd7;
    localparam logic [3:0] S_CBRANCH = 4'd8;
    localparam logic [3:0] S_UBRANCH = 4'd9;
    localparam logic [3:0] S_HALT    = 4'd15;

    logic [3:0]        r_state;
    logic [WAIT_W-1:0] r_wait;
    logic              r_halt;
    logic [1:0]        r_cause;
    logic [CNT_W-1:0]  r_retired;
    logic              r_is_load;
    logic              r_is_cbnz;

    logic [3:0] w_next;
    logic       w_wait_st;
    logic       w_timeout;
    logic       w_dec_load, w_dec_store, w_dec_rtype, w_dec_cbz, w_dec_cbnz, w_dec_b;

    assign w_dec_load  = (Op == 11'b111_1100_0010);
    assign w_dec_store = (Op == 11'b111_1100_0000);
    assign w_dec_rtype = (Op == 11'b100_0101_1000) || (Op == 11'b110_0101_1000) ||
                         (Op == 11'b100_0101_0000) || (Op == 11'b101_0101_0000);
    assign w_dec_cbz   = (Op[10:3] == 8'b1011_0100);
`ifdef CBNZ_EN
    assign w_dec_cbnz  = (Op[10:3] == 8'b1011_0101);
`else
    assign w_dec_cbnz  = 1'b0;
`endif
    assign w_dec_b     = (Op[10:5] == 6'b000101);

    assign w_wait_st = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_timeout = (WAIT_MAX != 0) && w_wait_st && !mem_ready && (r_wait == WAIT_LIM);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:   if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                if (w_dec_load || w_dec_store)   w_next = S_MEMADR;
                else if (w_dec_rtype)            w_next = S_EXECR;
                else if (w_dec_cbz || w_dec_cbnz) w_next = S_CBRANCH;
                else if (w_dec_b)                w_next = S_UBRANCH;
                else                             w_next = S_HALT;
            end
            S_MEMADR:  w_next = r_is_load ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (mem_ready) w_next = S_MEMWB;
            S_MEMWB:   w_next = S_FETCH;
            S_MEMWR:   if (mem_ready) w_next = S_FETCH;
            S_EXECR:   w_next = S_RWB;
            S_RWB:     w_next = S_FETCH;
            S_CBRANCH: w_next = S_FETCH;
            S_UBRANCH: w_next = S_FETCH;
            S_HALT:    w_next = S_HALT;
            default:   w_next = S_FETCH;
        endcase
        if (w_timeout) w_next = S_HALT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_halt    <= 1'b0;
            r_cause   <= 2'b00;
            r_retired <= '0;
            r_is_load <= 1'b0;
            r_is_cbnz <= 1'b0;
        end else begin
            r_state <= w_next;
            // Any cycle outside a waiting state, or a completed access, restarts the count.
            r_wait  <= (w_wait_st && !mem_ready) ? r_wait + WAIT_W'(1) : '0;
            if (w_next == S_HALT && r_state != S_HALT) begin
                r_halt  <= 1'b1;
                r_cause <= w_timeout ? 2'b10 : 2'b01;
            end
            if (PCWrite) r_retired <= r_retired + CNT_W'(1);
            // Captured once in DECODE so later states need not depend on Op staying put.
            if (r_state == S_DECODE) begin
                r_is_load <= w_dec_load;
                r_is_cbnz <= w_dec_cbnz;
            end
        end
    end

    always_comb begin
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        Reg2Loc  = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        RegWrite = 1'b0;
        MemtoReg = 1'b0;
        case (r_state)
            S_FETCH:   begin MemRead = 1'b1; IRWrite = mem_ready; end
            S_DECODE:  begin ALUSrcB = 2'b11; end
            S_MEMADR:  begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; Reg2Loc = 1'b1; end
            S_MEMRD:   begin MemRead = 1'b1; IorD = 1'b1; end
            S_MEMWB:   begin RegWrite = 1'b1; MemtoReg = 1'b1; PCWrite = 1'b1; end
            S_MEMWR:   begin MemWrite = 1'b1; IorD = 1'b1; Reg2Loc = 1'b1; PCWrite = mem_ready; end
            S_EXECR:   begin ALUSrcA = 1'b1; ALUOp = 2'b10; end
            S_RWB:     begin RegWrite = 1'b1; PCWrite = 1'b1; end
            S_CBRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b01;
                Reg2Loc = 1'b1;
                PCWrite = 1'b1;
                PCSrc   = r_is_cbnz ? !zero : zero;
            end
            S_UBRANCH: begin PCWrite = 1'b1; PCSrc = 1'b1; end
            default:   ;
        endcase
        if (reset) begin
            IorD     = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            PCSrc    = 1'b0;
            Reg2Loc  = 1'b0;
            ALUSrcA  = 1'b0;
            ALUSrcB  = 2'b00;
            ALUOp    = 2'b00;
            RegWrite = 1'b0;
            MemtoReg = 1'b0;
        end
    end

    assign halt    = r_halt;
    assign cause   = r_cause;
    assign retired = r_retired;
    assign state_o = r_state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into its expected
// per-cycle state/strobe trace from the opcode class and the memory-ready schedule.
module tb_multicycle_ctrl;
    localparam int CNT_W    = 4;
    localparam int WAIT_MAX = 4;

    localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MWB = 4, S_MW = 5;
    localparam int S_EX = 6, S_RWB = 7, S_CB = 8, S_UB = 9, S_H = 15;

    localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
    localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
    localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [10:0]      Op = '0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrcA;
    logic [1:0]       ALUSrcB, ALUOp;
    logic             RegWrite, MemtoReg, halt;
    logic [1:0]       cause;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state_o;
    logic [13:0]      w_strb;

    multicycle_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset(reset), .Op(Op), .zero(zero), .mem_ready(mem_ready),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .Reg2Loc(Reg2Loc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .halt(halt), .cause(cause), .retired(retired), .state_o(state_o)
    );

    assign w_strb = {IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrcA,
                     ALUSrcB, ALUOp, RegWrite, MemtoReg};

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int          exp_ret = 0;
    int          exp_st[$];
    bit          rdy_q[$];
    logic [10:0] rops [4] = '{11'b100_0101_1000, 11'b110_0101_1000,
                              11'b100_0101_0000, 11'b101_0101_0000};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // 0 LDUR, 1 STUR, 2 R-type, 3 CBZ, 4 CBNZ, 5 B, 6 illegal
    function automatic int classify(input logic [10:0] op);
        if (op == OP_LDUR) return 0;
        if (op == OP_STUR) return 1;
        for (int i = 0; i < 4; i++) if (op == rops[i]) return 2;
        if (op ==? 11'b101_1010_0???) return 3;
`ifdef CBNZ_EN
        if (op ==? 11'b101_1010_1???) return 4;
`endif
        if (op ==? 11'b000_101?_????) return 5;
        return 6;
    endfunction

    function automatic logic [13:0] exp_strobes(input int st, input logic rdy, input logic z,
                                                input bit cbnz);
        logic iord, mr, mw, irw, pcw, pcs, r2l, asa, rw, m2r;
        logic [1:0] asb, aop;
        {iord, mr, mw, irw, pcw, pcs, r2l, asa, rw, m2r} = '0;
        asb = 2'b00;
        aop = 2'b00;
        case (st)
            S_F:   begin mr = 1; irw = rdy; end
            S_D:   begin asb = 2'b11; end
            S_MA:  begin asa = 1; asb = 2'b10; r2l = 1; end
            S_MR:  begin mr = 1; iord = 1; end
            S_MWB: begin rw = 1; m2r = 1; pcw = 1; end
            S_MW:  begin mw = 1; iord = 1; r2l = 1; pcw = rdy; end
            S_EX:  begin asa = 1; aop = 2'b10; end
            S_RWB: begin rw = 1; pcw = 1; end
            S_CB:  begin asa = 1; aop = 2'b01; r2l = 1; pcw = 1; pcs = cbnz ? !z : z; end
            S_UB:  begin pcw = 1; pcs = 1; end
            default: ;
        endcase
        return {iord, mr, mw, irw, pcw, pcs, r2l, asa, asb, aop, rw, m2r};
    endfunction

    function automatic void push(input int st, input bit r);
        exp_st.push_back(st);
        rdy_q.push_back(r);
    endfunction

    // d low cycles then ready; WAIT_MAX or more low cycles times out.
    function automatic bit push_wait(input int st, input int d);
        if (d >= WAIT_MAX) begin
            repeat (WAIT_MAX) push(st, 1'b0);
            return 1'b0;
        end
        repeat (d) push(st, 1'b0);
        push(st, 1'b1);
        return 1'b1;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        zero = 1'($urandom_range(0, 1));
        #1;
        check_eq("rst_strobes", 32'(w_strb), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rst_state", 32'(state_o), S_F);
        check_eq("rst_halt", 32'(halt), 0);
        check_eq("rst_cause", 32'(cause), 0);
        check_eq("rst_retired", 32'(retired), 0);
        exp_ret = 0;
    endtask

    task automatic run_instr(input logic [10:0] op, input int df, input int dm, input logic z,
                             input int abort_at, output bit halted);
        int cls;
        int hcause;
        int n_pcw;
        cls = classify(op);
        hcause = 0;
        n_pcw = 0;
        halted = 1'b0;
        exp_st.delete();
        rdy_q.delete();
        if (!push_wait(S_F, df)) hcause = 2;
        else begin
            push(S_D, 1'($urandom_range(0, 1)));
            case (cls)
                0: begin
                    push(S_MA, 1'($urandom_range(0, 1)));
                    if (push_wait(S_MR, dm)) push(S_MWB, 1'($urandom_range(0, 1)));
                    else hcause = 2;
                end
                1: begin
                    push(S_MA, 1'($urandom_range(0, 1)));
                    if (!push_wait(S_MW, dm)) hcause = 2;
                end
                2: begin
                    push(S_EX, 1'($urandom_range(0, 1)));
                    push(S_RWB, 1'($urandom_range(0, 1)));
                end
                3, 4: push(S_CB, 1'($urandom_range(0, 1)));
                5: push(S_UB, 1'($urandom_range(0, 1)));
                default: hcause = 1;
            endcase
        end
        if (hcause != 0) repeat (3) push(S_H, 1'($urandom_range(0, 1)));

        for (int k = 0; k < exp_st.size(); k++) begin
            if (k == abort_at) return;
            Op = op;
            mem_ready = rdy_q[k];
            zero = (exp_st[k] == S_CB) ? z : 1'($urandom_range(0, 1));
            #1;
            check_eq("state", 32'(state_o), exp_st[k]);
            check_eq("strobes", 32'(w_strb), 32'(exp_strobes(exp_st[k], mem_ready, zero, cls == 4)));
            check_eq("retired", 32'(retired), exp_ret);
            check_eq("halt", 32'(halt), (exp_st[k] == S_H) ? 1 : 0);
            check_eq("cause", 32'(cause), (exp_st[k] == S_H) ? hcause : 0);
            if (PCWrite) n_pcw++;
            @(negedge clk);
        end
        if (hcause == 0) begin
            check_eq("pcwrite_count", n_pcw, 1);
            exp_ret = (exp_ret + 1) % (1 << CNT_W);
        end else begin
            check_eq("pcwrite_count", n_pcw, 0);
            halted = 1'b1;
        end
    endtask

    function automatic logic [10:0] rand_op();
        logic [10:0] r;
        r = 11'($urandom);
        case ($urandom_range(0, 9))
            0, 8:    return OP_LDUR;
            1:       return OP_STUR;
            2, 3, 9: return rops[$urandom_range(0, 3)];
            4:       return {8'b1011_0100, r[2:0]};
            5:       return {8'b1011_0101, r[2:0]};
            6:       return {6'b000101, r[4:0]};
            default: return r;
        endcase
    endfunction

    function automatic int rand_delay();
        if ($urandom_range(0, 19) == 0) return WAIT_MAX + int'($urandom_range(0, 1));
        return int'($urandom_range(0, 3));
    endfunction

    initial begin
        bit h;
        do_reset();
        run_instr(OP_ADD, 0, 0, 1'b0, -1, h);
        run_instr(OP_LDUR, 0, 3, 1'b0, -1, h);
        run_instr(11'b101_1010_0000, 0, 0, 1'b1, -1, h);
        run_instr(11'b101_1010_0101, 0, 0, 1'b0, -1, h);
        run_instr(OP_STUR, 1, 2, 1'b0, -1, h);
        run_instr(11'b000_1011_0110, 2, 0, 1'b0, -1, h);
        run_instr(rops[3], 3, 0, 1'b0, -1, h);
        run_instr(11'b111_1111_1111, 0, 0, 1'b0, -1, h);
        if (h) do_reset();
        run_instr(11'b101_1010_1011, 0, 0, 1'b0, -1, h);
        if (h) do_reset();
        run_instr(11'b101_1010_1000, 0, 0, 1'b1, -1, h);
        if (h) do_reset();
        run_instr(OP_ADD, WAIT_MAX, 0, 1'b0, -1, h);
        if (h) do_reset();
        run_instr(OP_STUR, 0, WAIT_MAX, 1'b0, -1, h);
        if (h) do_reset();
        run_instr(OP_ADD, 0, 0, 1'b0, -1, h);
        run_instr(OP_LDUR, 0, 3, 1'b0, 4, h);
        do_reset();
        run_instr(OP_ADD, 0, 0, 1'b0, -1, h);
        run_instr(OP_ADD, 0, 0, 1'b0, 3, h);
        do_reset();
        for (int i = 0; i < (1 << CNT_W); i++) run_instr(OP_ADD, 0, 0, 1'b0, -1, h);
        check_eq("retired_wrap", 32'(retired), 0);
        for (int i = 0; i < 150; i++) begin
            run_instr(rand_op(), rand_delay(), rand_delay(), 1'($urandom_range(0, 1)), -1, h);
            if (h) do_reset();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end
endmodule
